// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifetch_pkg;

   // Fetch controller states; FAULT is terminal until reset.
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

   // addi x0,x0,0 -- what decode sees whenever the fetch register is empty.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Byte distance between consecutive instruction words.
   localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/ifetch_pc_reg.sv
// Program-counter register with next-pc mux and address range/alignment check.
// Latency: pc updates one edge after load_redirect/load_step; fault flags are combinational.
// Backpressure: none; the caller decides when to load.
// Ports: clk/reset; load_redirect + redirect_pc (jump), load_step (pc += 4);
//        pc (current fetch address); redirect_bad / pc_bad (address unusable).
module ifetch_pc_reg #(
   parameter int          N        = 32,
   parameter int          IMEM_AW  = 6,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_redirect,
   input  logic         load_step,
   input  logic [N-1:0] redirect_pc,
   output logic [N-1:0] pc,
   output logic         redirect_bad,
   output logic         pc_bad
);
   import ifetch_pkg::*;

   // An address is unusable if it is not word aligned or lies past the end
   // of the instruction memory.
   function automatic logic addr_bad(input logic [N-1:0] a);
      return (a[1:0] != 2'b00) || (a[N-1:IMEM_AW+2] != '0);
   endfunction

   assign redirect_bad = addr_bad(redirect_pc);
   assign pc_bad       = addr_bad(pc);

   // Redirect wins over sequential advance; pc + 4 wraps naturally.
   always_ff @(posedge clk) begin
      if (reset)
         pc <= RESET_PC;
      else if (load_redirect)
         pc <= redirect_pc;
      else if (load_step)
         pc <= pc + N'(PC_STEP);
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the pc, reads imem, fills the fetch/decode register.
// Latency: one cycle from pc to fd_valid; sustains 1 instruction/cycle while fd_ready=1.
// Backpressure: fd_ready low with fd_valid high stalls fetch and holds every register.
// Ports: imem_addr/imem_instr (combinational imem); fd_valid/fd_ready/fd_instr/fd_pc
//        (decode handshake); redirect_valid/redirect_pc (flush); halt_req/resume/halted;
//        fault/fault_pc (sticky address fault); fetch_count (accepted instructions).
module ifetch_ctrl #(
   parameter int           N         = 32,
   parameter int           IMEM_AW   = 6,
   parameter logic [N-1:0] RESET_PC  = '0,
   parameter logic [N-1:0] NOP_INSTR = ifetch_pkg::NOP_INSTR
) (
   input  logic               clk,
   input  logic               reset,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [N-1:0]       imem_instr,
   output logic               fd_valid,
   input  logic               fd_ready,
   output logic [N-1:0]       fd_instr,
   output logic [N-1:0]       fd_pc,
   input  logic               redirect_valid,
   input  logic [N-1:0]       redirect_pc,
   input  logic               halt_req,
   input  logic               resume,
   output logic               halted,
   output logic               fault,
   output logic [N-1:0]       fault_pc,
   output logic [N-1:0]       fetch_count
);
   import ifetch_pkg::*;

   fetch_state_t state, state_nx;
   logic         fd_valid_nx, fault_nx, halted_nx;
   logic [N-1:0] fd_instr_nx, fd_pc_nx, fault_pc_nx;
   logic         ld_redirect, ld_step;
   logic [N-1:0] pc;
   logic         redirect_bad, pc_bad;
   logic         accept, slot_free;

   ifetch_pc_reg #(
      .N        (N),
      .IMEM_AW  (IMEM_AW),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk           (clk),
      .reset         (reset),
      .load_redirect (ld_redirect),
      .load_step     (ld_step),
      .redirect_pc   (redirect_pc),
      .pc            (pc),
      .redirect_bad  (redirect_bad),
      .pc_bad        (pc_bad)
   );

   assign imem_addr = pc[IMEM_AW+1:2];
   assign accept    = fd_valid && fd_ready;
   assign slot_free = !fd_valid || fd_ready;

   always_comb begin
      state_nx    = state;
      fd_valid_nx = fd_valid;
      fd_instr_nx = fd_instr;
      fd_pc_nx    = fd_pc;
      fault_nx    = fault;
      fault_pc_nx = fault_pc;
      ld_redirect = 1'b0;
      ld_step     = 1'b0;

      // Default drain: an accepted instruction leaves the register empty
      // unless a capture below refills it in the same cycle.
      if (accept) begin
         fd_valid_nx = 1'b0;
         fd_instr_nx = NOP_INSTR;
      end

      case (state)
         BOOT: state_nx = RUN;

         RUN: begin
            if (redirect_valid) begin
               fd_valid_nx = 1'b0;
               fd_instr_nx = NOP_INSTR;
               if (redirect_bad) begin
                  state_nx    = FAULT;
                  fault_nx    = 1'b1;
                  fault_pc_nx = redirect_pc;
               end else begin
                  ld_redirect = 1'b1;
                  state_nx    = halt_req ? HALT : RUN;
               end
            end else if (halt_req) begin
               state_nx = HALT;
            end else if (slot_free) begin
               // A pc that ran off the end of memory faults on the capture
               // attempt that would have used it, not when it was produced.
               if (pc_bad) begin
                  state_nx    = FAULT;
                  fault_nx    = 1'b1;
                  fault_pc_nx = pc;
                  fd_valid_nx = 1'b0;
                  fd_instr_nx = NOP_INSTR;
               end else begin
                  fd_valid_nx = 1'b1;
                  fd_instr_nx = imem_instr;
                  fd_pc_nx    = pc;
                  ld_step     = 1'b1;
               end
            end
         end

         HALT: begin
            if (redirect_valid) begin
               fd_valid_nx = 1'b0;
               fd_instr_nx = NOP_INSTR;
               if (redirect_bad) begin
                  state_nx    = FAULT;
                  fault_nx    = 1'b1;
                  fault_pc_nx = redirect_pc;
               end else begin
                  ld_redirect = 1'b1;
                  state_nx    = resume ? RUN : HALT;
               end
            end else if (resume) begin
               state_nx = RUN;
            end
         end

         FAULT: begin
            fd_valid_nx = 1'b0;
            fd_instr_nx = NOP_INSTR;
         end
      endcase

      halted_nx = (state_nx == HALT) || (state_nx == FAULT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BOOT;
         fd_valid    <= 1'b0;
         fd_instr    <= NOP_INSTR;
         fd_pc       <= '0;
         fault       <= 1'b0;
         fault_pc    <= '0;
         fetch_count <= '0;
         halted      <= 1'b0;
      end else begin
         state       <= state_nx;
         fd_valid    <= fd_valid_nx;
         fd_instr    <= fd_instr_nx;
         fd_pc       <= fd_pc_nx;
         fault       <= fault_nx;
         fault_pc    <= fault_pc_nx;
         fetch_count <= fetch_count + {{(N-1){1'b0}}, accept};
         halted      <= halted_nx;
      end
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios followed by randomized traffic,
// checked against a behavioural model and an accepted-instruction scoreboard.
module tb_ifetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  imem_addr;
   logic [31:0] imem_instr;
   logic        fd_valid;
   logic        fd_ready = 1'b0;
   logic [31:0] fd_instr;
   logic [31:0] fd_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt_req = 1'b0;
   logic        resume = 1'b0;
   logic        halted;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_count;

   logic [31:0] mem [64];
   assign imem_instr = mem[imem_addr];

   always #5 clk = ~clk;

   ifetch_ctrl #(.N(32), .IMEM_AW(6), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .fd_valid       (fd_valid),
      .fd_ready       (fd_ready),
      .fd_instr       (fd_instr),
      .fd_pc          (fd_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .resume         (resume),
      .halted         (halted),
      .fault          (fault),
      .fault_pc       (fault_pc),
      .fetch_count    (fetch_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
   int          m_mode = M_BOOT;
   bit          m_live = 1'b0;
   bit          m_valid = 1'b0;
   logic [31:0] m_pc = '0, m_instr = NOP, m_fdpc = '0, m_cnt = '0, m_fpc = '0;
   bit          m_fault = 1'b0, m_halted = 1'b0;
   logic [31:0] exp_pc_q[$];
   logic [31:0] exp_in_q[$];

   // Unusable fetch address: misaligned or beyond the 256-byte memory.
   function automatic bit bad_addr(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'd256);
   endfunction

   task automatic m_go_fault(input logic [31:0] a);
      m_mode  = M_FAULT;
      m_fault = 1'b1;
      m_fpc   = a;
      m_valid = 1'b0;
      m_instr = NOP;
   endtask

   task automatic m_flush();
      m_valid = 1'b0;
      m_instr = NOP;
   endtask

   always @(posedge clk) begin
      bit acc;
      acc = m_valid && fd_ready;
      if (acc) begin
         exp_pc_q.push_back(m_fdpc);
         exp_in_q.push_back(m_instr);
      end
      if (reset) begin
         m_live = 1'b1; m_mode = M_BOOT; m_valid = 1'b0; m_pc = '0; m_instr = NOP;
         m_fdpc = '0; m_cnt = '0; m_fpc = '0; m_fault = 1'b0; m_halted = 1'b0;
      end else if (m_live) begin
         if (acc) begin
            m_cnt = m_cnt + 1;
            m_valid = 1'b0;
            m_instr = NOP;
         end
         if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
         end else if (m_mode == M_RUN) begin
            if (redirect_valid) begin
               m_flush();
               if (bad_addr(redirect_pc)) m_go_fault(redirect_pc);
               else begin
                  m_pc = redirect_pc;
                  if (halt_req) m_mode = M_HALT;
               end
            end else if (halt_req) begin
               m_mode = M_HALT;
            end else if (!m_valid) begin
               // slot was free (either empty or just accepted above)
               if (bad_addr(m_pc)) m_go_fault(m_pc);
               else begin
                  m_valid = 1'b1;
                  m_instr = mem[m_pc / 4];
                  m_fdpc  = m_pc;
                  m_pc    = m_pc + 4;
               end
            end
         end else if (m_mode == M_HALT) begin
            if (redirect_valid) begin
               m_flush();
               if (bad_addr(redirect_pc)) m_go_fault(redirect_pc);
               else begin
                  m_pc = redirect_pc;
                  if (resume) m_mode = M_RUN;
               end
            end else if (resume) begin
               m_mode = M_RUN;
            end
         end else begin
            m_valid = 1'b0;
            m_instr = NOP;
         end
         m_halted = (m_mode == M_HALT) || (m_mode == M_FAULT);
      end
   end

   // ---------------- monitor ----------------
   bit          obs_acc = 1'b0;
   logic [31:0] obs_pc, obs_instr;

   always @(negedge clk) begin
      obs_acc   = (fd_valid === 1'b1) && fd_ready;
      obs_pc    = fd_pc;
      obs_instr = fd_instr;
      if (m_live) begin
         chk("fd_valid",    32'(fd_valid),  32'(m_valid));
         chk("fd_instr",    fd_instr,       m_instr);
         chk("fd_pc",       fd_pc,          m_fdpc);
         chk("halted",      32'(halted),    32'(m_halted));
         chk("fault",       32'(fault),     32'(m_fault));
         chk("fault_pc",    fault_pc,       m_fpc);
         chk("fetch_count", fetch_count,    m_cnt);
         chk("imem_addr",   32'(imem_addr), 32'(m_pc[7:2]));
      end
   end

   // Scoreboard: every accept the DUT presented must match the model's next entry.
   always @(posedge clk) begin
      #3;
      if (obs_acc) begin
         if (exp_pc_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow actual=accept(pc=%h) required=no accept", obs_pc);
         end else begin
            chk("sb_pc",    obs_pc,    exp_pc_q.pop_front());
            chk("sb_instr", obs_instr, exp_in_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc,
                       input bit hr, input bit rs, input bit rst);
      fd_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt_req       = hr;
      resume         = rs;
      reset          = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic run(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(rdy, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int fault_age;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      mem[8] = 32'h88;

      // sequential fetch after reset
      do_reset();
      run(5, 1'b1);
      chk("t1_count", fetch_count, 32'd3);
      chk("t1_instr", fd_instr, 32'h44);
      chk("t1_pc",    fd_pc,    32'hC);

      // back-pressure stall after the first capture
      do_reset();
      run(2, 1'b1);
      run(3, 1'b0);
      chk("t2_hold_instr", fd_instr, 32'h11);
      chk("t2_hold_addr",  32'(imem_addr), 32'd1);
      run(3, 1'b1);

      // redirect to 0x20 with an instruction in the register
      step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
      chk("t3_flush", 32'(fd_valid), 32'd0);
      run(1, 1'b1);
      chk("t3_pc",    fd_pc,    32'h20);
      chk("t3_instr", fd_instr, 32'h88);
      run(2, 1'b1);

      // misaligned redirect faults; resume ignored
      step(1'b1, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
      chk("t4_fault",    32'(fault),  32'd1);
      chk("t4_fault_pc", fault_pc,    32'h22);
      chk("t4_halted",   32'(halted), 32'd1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("t4_sticky", 32'(fault), 32'd1);
      chk("t4_valid",  32'(fd_valid), 32'd0);

      // run off the end of memory
      do_reset();
      run(70, 1'b1);
      chk("t5_fault_pc", fault_pc, 32'h100);
      chk("t5_count",    fetch_count, 32'd64);

      // halt and redirect together, then resume
      do_reset();
      run(3, 1'b1);
      step(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
      chk("t6_halted", 32'(halted), 32'd1);
      chk("t6_addr",   32'(imem_addr), 32'h10);
      run(2, 1'b1);
      step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      run(1, 1'b1);
      chk("t6_pc",    fd_pc, 32'h40);
      chk("t6_valid", 32'(fd_valid), 32'd1);

      // reset in the middle of a stall
      run(3, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("t7_valid", 32'(fd_valid), 32'd0);
      chk("t7_instr", fd_instr, NOP);
      chk("t7_fd_pc", fd_pc, 32'd0);
      chk("t7_count", fetch_count, 32'd0);
      chk("t7_addr",  32'(imem_addr), 32'd0);

      // randomized traffic
      fault_age = 0;
      for (int i = 0; i < 3000; i++) begin
         bit rdy, rv, hr, rs, rst;
         logic [31:0] rpc;
         int sel;
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 9) == 0);
         hr  = ($urandom_range(0, 19) == 0);
         rs  = ($urandom_range(0, 4) == 0);
         sel = $urandom_range(0, 19);
         if (sel == 0)      rpc = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
         else if (sel == 1) rpc = 32'h100 + (32'($urandom_range(0, 255)) << 2);
         else               rpc = 32'($urandom_range(0, 63)) << 2;
         fault_age = m_fault ? fault_age + 1 : 0;
         rst = ($urandom_range(0, 199) == 0) || (fault_age > 6);
         step(rdy, rv, rpc, hr, rs, rst);
      end

      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      #5;
      chk("sb_empty", 32'(exp_pc_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch controller. It owns the program counter and drives the word address of the combinational instruction memory.
- It registers the returned instruction into a fetch/decode pipeline register with a valid/ready handshake.
- It handles branch/jump redirects (flush), back-pressure stalls, halt/resume and address faults.
- It sits between the instruction memory and the decode stage of the RISC-V core.

Parameters:
- N, 32, data/PC width in bits.
- IMEM_AW, 6, instruction-memory word-address width; depth is 2**IMEM_AW words.
- RESET_PC, 0, byte address fetched first after reset.
- NOP_INSTR, 32'h00000013, value held on fd_instr when no valid instruction (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  IMEM_AW  word address to instruction memory, equal to pc[IMEM_AW+1:2].
- imem_instr  in  N  instruction read combinationally from instruction memory at imem_addr.
- fd_valid  out  1  fetch/decode register holds a valid instruction.
- fd_ready  in  1  decode accepts fd_instr this cycle.
- fd_instr  out  N  fetched instruction.
- fd_pc  out  N  byte address of fd_instr.
- redirect_valid  in  1  branch/jump taken, flush and refetch.
- redirect_pc  in  N  redirect target byte address.
- halt_req  in  1  stop fetching.
- resume  in  1  leave HALT.
- halted  out  1  state is HALT or FAULT.
- fault  out  1  sticky address fault.
- fault_pc  out  N  offending byte address.
- fetch_count  out  N  count of accepted instructions (fd_valid && fd_ready).

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high.
- Reset values: pc=RESET_PC, state=BOOT, fd_valid=0, fd_instr=NOP_INSTR, fd_pc=0, fault=0, fault_pc=0, fetch_count=0, halted=0.
- States: BOOT, RUN, HALT, FAULT. Encoding is a shared enum.
- BOOT -> RUN unconditionally after one cycle. No fetch occurs in BOOT.
- Accept event: fd_valid && fd_ready. Each accept increments fetch_count by 1; the counter wraps mod 2**N. Accepts are counted in every state.
- Slot free: !fd_valid || fd_ready.
- RUN, evaluated in priority order each cycle:
  1. redirect_valid. Flush: fd_valid<=0, fd_instr<=NOP_INSTR. Target check:
     - redirect_pc[1:0]!=0 or redirect_pc[N-1:IMEM_AW+2]!=0: go FAULT, fault<=1, fault_pc<=redirect_pc, pc unchanged.
     - Otherwise pc<=redirect_pc. Go HALT if halt_req is also high, else stay RUN.
     - The instruction at the target is fetched no earlier than the next cycle.
  2. halt_req (no redirect). Go HALT. No new capture; pc unchanged. An in-flight fd_valid drains normally through fd_ready.
  3. Slot free. Capture: fd_instr<=imem_instr, fd_pc<=pc, fd_valid<=1, pc<=pc+4.
     - pc+4 wraps mod 2**N.
     - If the incremented pc lies beyond the memory (bits [N-1:IMEM_AW+2] non-zero): the current capture still occurs, and on the next attempted capture the block goes FAULT with fault_pc=that pc and no capture.
  4. Else stall: all registers hold.
- Fetch latency: one cycle from pc to fd_valid. Sustained throughput is 1 instruction/cycle while fd_ready=1.
- HALT:
  - No capture. fd_valid clears on accept.
  - redirect_valid still updates pc (with the same fault check) and flushes.
  - resume -> RUN next cycle. resume is ignored outside HALT.
- FAULT:
  - Terminal until reset. No capture; fd_valid cleared immediately; redirect, halt_req and resume ignored.
- halted is registered, high in HALT or FAULT.
- imem_addr is combinational from pc.
- Reset mid-operation: reset values apply next edge regardless of state or handshake.

Decomposition:
- Package ifetch_pkg holds:
  - state enum fetch_state_t {BOOT, RUN, HALT, FAULT};
  - NOP_INSTR constant;
  - PC_STEP=4.
- Natural sub-module: ifetch_pc_reg (pc register with next-pc mux and range/alignment check producing a fault flag). Everything else is in the top module.

Test Plan:
- Reset, fd_ready=1, imem holds 0x11,0x22,0x33 at words 0..2 -> BOOT for 1 cycle, then fd_instr 0x11/0x22/0x33 with fd_pc 0/4/8 on consecutive cycles; fetch_count=3.
- fd_ready=0 for 3 cycles after first capture -> fd_instr holds 0x11 and pc holds 4; on release, 0x22 follows next cycle; no duplicate, no skip.
- redirect_valid with redirect_pc=0x20 while fd_valid=1 -> fd_valid=0 next cycle, then fd_pc=0x20 with word-8 instruction; fetch_count excludes the flushed instruction.
- redirect_pc=0x22 (misaligned) -> fault=1, fault_pc=0x22, halted=1, fd_valid=0; resume has no effect until reset.
- Sequential fetch reaching pc=0xFC (last word, IMEM_AW=6) -> 0xFC instruction delivered, then FAULT with fault_pc=0x100.
- halt_req and redirect_pc=0x40 in the same cycle -> HALT with pc=0x40; resume two cycles later -> next fd_pc=0x40. Also assert reset mid-stall -> all outputs return to reset values one edge later.
